// File: rtl/rx_cmd_parser_pkg.sv
// Shared types for the UART receive command parser.
// Opcodes, command type encodings and parser states.
package rx_cmd_parser_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    T_RF_WR   = 2'd0,
    T_RF_RD   = 2'd1,
    T_ALU_OP  = 2'd2,
    T_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_WDATA,
    S_GET_OPA,
    S_GET_OPB,
    S_GET_FUNC,
    S_ISSUE
  } rx_state_e;

endpackage

// File: rtl/rx_cmd_parser_timeout.sv
// Inter-byte idle counter with clear/enable and terminal count.
// Ports: clk, rst_n, clr, en in; tc out (count reached TIMEOUT).
module rx_byte_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/rx_cmd_parser.sv
// Assembles UART bytes into command frames, issues via valid/ready.
// Ports: CLK/RST, RX byte strobe+errors in; CMD_* handshake, ERR_CNT, BUSY out.
module rx_cmd_parser
  import rx_cmd_parser_pkg::*;
#(
  parameter int DATA    = 8,
  parameter int ADDR    = 4,
  parameter int FUNC_W  = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA-1:0]   RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              RX_PAR_ERR,
  input  logic              RX_FRM_ERR,
  input  logic              CMD_READY,
  output logic              CMD_VALID,
  output logic [1:0]        CMD_TYPE,
  output logic [ADDR-1:0]   CMD_ADDR,
  output logic [DATA-1:0]   CMD_WDATA,
  output logic [DATA-1:0]   CMD_OPA,
  output logic [DATA-1:0]   CMD_OPB,
  output logic [FUNC_W-1:0] CMD_FUNC,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic              BUSY
);

  rx_state_e state_q, state_d;
  cmd_type_e type_q, type_d;

  logic [ADDR-1:0]   addr_q;
  logic [DATA-1:0]   wdata_q, opa_q, opb_q;
  logic [FUNC_W-1:0] func_q;
  logic [CNT_W-1:0]  err_q;

  logic good, bad, in_get, tc, err_inc;
  logic ld_type, ld_addr, ld_wdata;
  logic ld_opa, ld_opb, ld_func;

  assign bad  = RX_D_VLD && (RX_PAR_ERR || RX_FRM_ERR);
  assign good = RX_D_VLD && !RX_PAR_ERR && !RX_FRM_ERR;

  assign in_get = (state_q != S_IDLE) && (state_q != S_ISSUE);

  rx_byte_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (RX_D_VLD || (state_d != state_q)),
    .en    (in_get),
    .tc    (tc)
  );

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    err_inc  = 1'b0;
    ld_type  = 1'b0;
    ld_addr  = 1'b0;
    ld_wdata = 1'b0;
    ld_opa   = 1'b0;
    ld_opb   = 1'b0;
    ld_func  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (good) begin
          ld_type = 1'b1;
          unique case (1'b1)
            RX_P_DATA == DATA'(CMD_RF_WR): begin
              type_d  = T_RF_WR;
              state_d = S_GET_ADDR;
            end
            RX_P_DATA == DATA'(CMD_RF_RD): begin
              type_d  = T_RF_RD;
              state_d = S_GET_ADDR;
            end
            RX_P_DATA == DATA'(CMD_ALU_OP): begin
              type_d  = T_ALU_OP;
              state_d = S_GET_OPA;
            end
            RX_P_DATA == DATA'(CMD_ALU_NOP): begin
              type_d  = T_ALU_NOP;
              state_d = S_GET_FUNC;
            end
            default: begin
              ld_type = 1'b0;
              err_inc = 1'b1;
            end
          endcase
        end else if (bad) begin
          err_inc = 1'b1;
        end
      end
      S_GET_ADDR: if (good) begin
        ld_addr = 1'b1;
        state_d = (type_q == T_RF_WR) ? S_GET_WDATA : S_ISSUE;
      end
      S_GET_WDATA: if (good) begin
        ld_wdata = 1'b1;
        state_d  = S_ISSUE;
      end
      S_GET_OPA: if (good) begin
        ld_opa  = 1'b1;
        state_d = S_GET_OPB;
      end
      S_GET_OPB: if (good) begin
        ld_opb  = 1'b1;
        state_d = S_GET_FUNC;
      end
      S_GET_FUNC: if (good) begin
        ld_func = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Any strobe here is an overrun; the held command is untouched.
        err_inc = RX_D_VLD;
        if (CMD_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort paths shared by every field-collecting state.
    // A byte arriving on the terminal cycle takes priority.
    if (in_get) begin
      if (bad || (!RX_D_VLD && tc)) begin
        state_d = S_IDLE;
        err_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      type_q  <= T_RF_WR;
      addr_q  <= '0;
      wdata_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      func_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld_type)  type_q  <= type_d;
      if (ld_addr)  addr_q  <= RX_P_DATA[ADDR-1:0];
      if (ld_wdata) wdata_q <= RX_P_DATA;
      if (ld_opa)   opa_q   <= RX_P_DATA;
      if (ld_opb)   opb_q   <= RX_P_DATA;
      if (ld_func)  func_q  <= RX_P_DATA[FUNC_W-1:0];
      if (err_inc && (err_q != '1)) err_q <= err_q + CNT_W'(1);
    end
  end

  assign CMD_VALID = (state_q == S_ISSUE);
  assign BUSY      = (state_q != S_IDLE);
  assign CMD_TYPE  = type_q;
  assign CMD_ADDR  = addr_q;
  assign CMD_WDATA = wdata_q;
  assign CMD_OPA   = opa_q;
  assign CMD_OPB   = opb_q;
  assign CMD_FUNC  = func_q;
  assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed bench for rx_cmd_parser.
// Table-driven RF frames plus hand-written multi-cycle sequences.
module tb_rx_cmd_parser;

  localparam int TO = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD, RX_PAR_ERR, RX_FRM_ERR, CMD_READY;
  logic       CMD_VALID, BUSY;
  logic [1:0] CMD_TYPE;
  logic [3:0] CMD_ADDR, CMD_FUNC;
  logic [7:0] CMD_WDATA, CMD_OPA, CMD_OPB, ERR_CNT;

  int n_chk = 0;
  int n_err = 0;

  rx_cmd_parser #(.TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RX_PAR_ERR (RX_PAR_ERR),
    .RX_FRM_ERR (RX_FRM_ERR),
    .CMD_READY  (CMD_READY),
    .CMD_VALID  (CMD_VALID),
    .CMD_TYPE   (CMD_TYPE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .CMD_OPA    (CMD_OPA),
    .CMD_OPB    (CMD_OPB),
    .CMD_FUNC   (CMD_FUNC),
    .ERR_CNT    (ERR_CNT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       rdy;
    logic       valid;
    logic       busy;
    logic [1:0] typ;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic p, input logic f, input logic r);
    RX_D_VLD   = v;
    RX_P_DATA  = d;
    RX_PAR_ERR = p;
    RX_FRM_ERR = f;
    CMD_READY  = r;
    @(posedge CLK);
    #1;
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    RX_FRM_ERR = 1'b0;
  endtask

  initial begin
    int hi;
    tbl[0] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 2'd0, 4'h0, 8'h00, 8'd0};
    tbl[1] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 2'd0, 4'h5, 8'h00, 8'd0};
    tbl[2] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 2'd0, 4'h5, 8'h3C, 8'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 4'h5, 8'h3C, 8'd0};
    tbl[4] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 4'h5, 8'h3C, 8'd1};
    tbl[5] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 2'd1, 4'h5, 8'h3C, 8'd1};
    tbl[6] = '{1'b1, 8'hF7, 1'b1, 1'b1, 1'b1, 2'd1, 4'h7, 8'h3C, 8'd1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 4'h7, 8'h3C, 8'd1};

    RST = 1'b0;
    RX_P_DATA = '0;
    RX_D_VLD = 0;
    RX_PAR_ERR = 0;
    RX_FRM_ERR = 0;
    CMD_READY = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", CMD_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR_CNT, 0);
    chk("rst_fields", {CMD_TYPE, CMD_ADDR, CMD_WDATA,
                       CMD_OPA, CMD_OPB, CMD_FUNC}, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].vld, tbl[i].d, 1'b0, 1'b0, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), CMD_VALID, tbl[i].valid);
      chk($sformatf("v%0d_busy", i), BUSY, tbl[i].busy);
      chk($sformatf("v%0d_type", i), CMD_TYPE, tbl[i].typ);
      chk($sformatf("v%0d_addr", i), CMD_ADDR, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), CMD_WDATA, tbl[i].wdata);
      chk($sformatf("v%0d_err", i), ERR_CNT, tbl[i].err);
    end

    // Parity error aborts a frame, next frame still parses.
    cyc(1, 8'hAA, 0, 0, 1);
    cyc(1, 8'h02, 0, 0, 1);
    cyc(1, 8'h77, 1, 0, 1);
    chk("perr_busy", BUSY, 0);
    chk("perr_err", ERR_CNT, 2);
    cyc(1, 8'hDD, 0, 0, 1);
    cyc(1, 8'h09, 0, 0, 1);
    chk("nop_valid", CMD_VALID, 1);
    chk("nop_type", CMD_TYPE, 3);
    chk("nop_func", CMD_FUNC, 9);
    cyc(0, 8'h00, 0, 0, 1);
    chk("nop_done", CMD_VALID, 0);

    // Back-pressure: valid held through 10 stalled cycles.
    cyc(1, 8'hCC, 0, 0, 0);
    cyc(1, 8'h12, 0, 0, 0);
    cyc(1, 8'h34, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0);
    hi = 0;
    for (int i = 0; i <= 10; i++) begin
      if (CMD_VALID) hi++;
      cyc(0, 8'h00, 0, 0, i == 10);
    end
    chk("bp_cycles", hi, 11);
    chk("bp_valid", CMD_VALID, 0);
    chk("bp_busy", BUSY, 0);
    chk("bp_ops", {CMD_OPA, CMD_OPB, CMD_FUNC}, {8'h12, 8'h34, 4'h3});
    chk("bp_err", ERR_CNT, 2);

    // Timeout: abort after TO idle cycles in GET_OPB.
    cyc(1, 8'hCC, 0, 0, 1);
    cyc(1, 8'h01, 0, 0, 1);
    repeat (TO) cyc(0, 8'h00, 0, 0, 1);
    chk("to_last_busy", BUSY, 1);
    chk("to_last_err", ERR_CNT, 2);
    cyc(0, 8'h00, 0, 0, 1);
    chk("to_busy", BUSY, 0);
    chk("to_err", ERR_CNT, 3);

    // Byte on the terminal cycle wins.
    cyc(1, 8'hCC, 0, 0, 1);
    cyc(1, 8'h01, 0, 0, 1);
    repeat (TO) cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h40, 0, 0, 1);
    chk("tc_busy", BUSY, 1);
    chk("tc_err", ERR_CNT, 3);
    cyc(1, 8'h05, 0, 0, 1);
    chk("tc_valid", CMD_VALID, 1);
    chk("tc_ops", {CMD_OPA, CMD_OPB, CMD_FUNC}, {8'h01, 8'h40, 4'h5});
    cyc(0, 8'h00, 0, 0, 1);

    // Overrun while stalled in ISSUE, and on the handshake cycle.
    cyc(1, 8'hDD, 0, 0, 0);
    cyc(1, 8'h0A, 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    cyc(1, 8'h01, 0, 0, 0);
    chk("ovr_valid", CMD_VALID, 1);
    chk("ovr_err", ERR_CNT, 5);
    chk("ovr_fields", {CMD_TYPE, CMD_FUNC}, {2'd3, 4'hA});
    cyc(1, 8'hAA, 0, 0, 1);
    chk("ovr_hs_err", ERR_CNT, 6);
    chk("ovr_hs_busy", BUSY, 0);

    // Framing error in IDLE counts.
    cyc(1, 8'hAA, 0, 1, 1);
    chk("ferr_idle_err", ERR_CNT, 7);
    chk("ferr_idle_busy", BUSY, 0);

    // Saturation.
    repeat (260) cyc(1, 8'h00, 0, 0, 1);
    chk("sat_err", ERR_CNT, 255);

    // Asynchronous reset mid-frame.
    cyc(1, 8'hCC, 0, 0, 1);
    cyc(1, 8'h11, 0, 0, 1);
    chk("mid_busy", BUSY, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_valid", CMD_VALID, 0);
    chk("arst_err", ERR_CNT, 0);
    chk("arst_fields", {CMD_TYPE, CMD_ADDR, CMD_WDATA,
                        CMD_OPA, CMD_OPB, CMD_FUNC}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(0, 8'h00, 0, 0, 1);
    chk("post_busy", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
